// File: rtl/tmds_out_seq.sv
// Start-up sequencer and word feeder for a 3-channel 10:1 TMDS serializer.
// Waits for a stable PLL lock, holds the serdes in reset, trains with control symbols, then streams words.
module tmds_out_seq #(
   parameter int unsigned LOCK_CYCLES  = 1024,
   parameter int unsigned RST_CYCLES   = 16,
   parameter int unsigned TRAIN_CYCLES = 64,
   parameter logic [9:0]  CTRL_SYM     = 10'b1101010100
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            pll_lock_i,
   input  logic            pix_valid_i,
   input  logic [9:0]      tmds_ch0_i,
   input  logic [9:0]      tmds_ch1_i,
   input  logic [9:0]      tmds_ch2_i,
   output logic [9:0][2:0] tmds_d_o,
   output logic            serdes_rst_o,
   output logic            ready_o,
   output logic [7:0]      lock_loss_o
);

   localparam int unsigned MAX_LR = (LOCK_CYCLES > RST_CYCLES) ? LOCK_CYCLES : RST_CYCLES;
   localparam int unsigned MAX_C  = (MAX_LR > TRAIN_CYCLES) ? MAX_LR : TRAIN_CYCLES;
   localparam int unsigned CW     = $clog2(MAX_C + 1);

   typedef enum logic [1:0] {
      WAIT_LOCK,
      RST_HOLD,
      PREAMBLE,
      RUN
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          lock_m;
   logic          lock_s;

   // Spread three channel words into the bit-major output layout: d[n][c] = bit n of channel c.
   function automatic logic [9:0][2:0] pack3(input logic [9:0] c0,
                                             input logic [9:0] c1,
                                             input logic [9:0] c2);
      logic [9:0][2:0] r;
      for (int unsigned n = 0; n < 10; n++) begin
         r[n][0] = c0[n];
         r[n][1] = c1[n];
         r[n][2] = c2[n];
      end
      return r;
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_lock_i;
         lock_s <= lock_m;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state        <= WAIT_LOCK;
         cnt          <= '0;
         serdes_rst_o <= 1'b1;
         tmds_d_o     <= '0;
         ready_o      <= 1'b0;
         lock_loss_o  <= '0;
      end else if (state != WAIT_LOCK && !lock_s) begin
         // Lock loss outranks any terminal count reached in the same cycle.
         state        <= WAIT_LOCK;
         cnt          <= '0;
         serdes_rst_o <= 1'b1;
         tmds_d_o     <= '0;
         ready_o      <= 1'b0;
         if (lock_loss_o != 8'hFF) lock_loss_o <= lock_loss_o + 8'd1;
      end else begin
         unique case (state)
            WAIT_LOCK: begin
               serdes_rst_o <= 1'b1;
               ready_o      <= 1'b0;
               tmds_d_o     <= '0;
               if (!lock_s) begin
                  cnt <= '0;
               end else if (cnt == CW'(LOCK_CYCLES - 1)) begin
                  state    <= RST_HOLD;
                  cnt      <= '0;
                  tmds_d_o <= pack3(CTRL_SYM, CTRL_SYM, CTRL_SYM);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RST_HOLD: begin
               tmds_d_o <= pack3(CTRL_SYM, CTRL_SYM, CTRL_SYM);
               if (cnt == CW'(RST_CYCLES - 1)) begin
                  state        <= PREAMBLE;
                  cnt          <= '0;
                  serdes_rst_o <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            PREAMBLE: begin
               tmds_d_o <= pack3(CTRL_SYM, CTRL_SYM, CTRL_SYM);
               if (cnt == CW'(TRAIN_CYCLES - 1)) begin
                  state   <= RUN;
                  cnt     <= '0;
                  ready_o <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RUN: begin
               if (pix_valid_i) tmds_d_o <= pack3(tmds_ch0_i, tmds_ch1_i, tmds_ch2_i);
               else             tmds_d_o <= pack3(CTRL_SYM, CTRL_SYM, CTRL_SYM);
            end
            default: state <= WAIT_LOCK;
         endcase
      end
   end

endmodule
